// File: rtl/and_share_arbiter.sv
// Round-robin arbiter sharing one registered WIDTH-bit AND unit among NREQ requesters; optional counters via AND_SHARE_STATS_EN.
// Latency: 1 cycle from accepted operand handshake to res_valid; 1 result/cycle with res_ready held high.
// Backpressure: while the result register is full and res_ready=0, every req_ready is 0 and nothing is consumed.
module and_share_arbiter #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [IDW-1:0]        res_id,
    output logic                  busy
`ifdef AND_SHARE_STATS_EN
    ,
    output logic [15:0]           grant_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             can_accept;
    logic             xfer;

    // The output register can take new data when empty or when it drains this cycle.
    assign can_accept = (state_q == ST_EMPTY) | res_ready;
    assign xfer       = rst_n & can_accept & win_found;

    // Round-robin scan starting one past the last winner; also muxes the winner's operands.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_a     = '0;
        win_b     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!win_found && (j == (int'(last_grant_q) + k) % NREQ) && req_valid[j]) begin
                    win_found = 1'b1;
                    win_idx   = IDW'(j);
                    win_a     = req_a[j*WIDTH +: WIDTH];
                    win_b     = req_b[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // One-hot grant to the winner only; held low during reset.
    always_comb begin
        req_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            req_ready[j] = xfer & (win_idx == IDW'(j));
        end
    end

    // Output register FSM: load on transfer, drain to EMPTY when consumed with no refill.
    always_comb begin
        state_d      = state_q;
        res_data_d   = res_data_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            state_d      = ST_FULL;
            res_data_d   = win_a & win_b;
            res_id_d     = win_idx;
            last_grant_d = win_idx;
        end else if ((state_q == ST_FULL) && res_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // State registers; pointer resets to NREQ-1 so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            res_data_q   <= '0;
            res_id_q     <= '0;
            last_grant_q <= IDW'(NREQ - 1);
        end else begin
            state_q      <= state_d;
            res_data_q   <= res_data_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign busy      = res_valid;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;

`ifdef AND_SHARE_STATS_EN
    logic [15:0] grant_cnt_q, grant_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall_cyc;

    // A stall cycle is a full, blocked result register with someone waiting upstream.
    assign stall_cyc = (state_q == ST_FULL) & ~res_ready & (|req_valid);

    // Saturating event counters.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (xfer && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_d = grant_cnt_q + 16'd1;
        end
        if (stall_cyc && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_and_share_arbiter.sv
// Directed bench for and_share_arbiter with a transaction-level reference model.
// Model state is advanced at each rising edge; outputs are compared on the falling edge.
// Inputs change 1 time unit after the rising edge.
module tb_and_share_arbiter;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic [IDW-1:0]        res_id;
    logic                  busy;
`ifdef AND_SHARE_STATS_EN
    logic [15:0]           grant_cnt;
    logic [15:0]           stall_cnt;
`endif

    int nerr = 0;
    int nchk = 0;

    and_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy)
`ifdef AND_SHARE_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // First valid requester in round-robin order after ptr, or -1.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model: one result slot, a pointer, and two counters.
    bit               started = 0;
    bit               m_full;
    logic [WIDTH-1:0] m_data;
    int               m_id;
    int               m_ptr;
    int               m_gcnt;
    int               m_scnt;

    always @(posedge clk) begin
        int w;
        started = 1;
        if (!rst_n) begin
            m_full = 0; m_data = '0; m_id = 0; m_ptr = NREQ - 1; m_gcnt = 0; m_scnt = 0;
        end else begin
            if (m_full && !res_ready && (req_valid != 0) && m_scnt < 65535) m_scnt++;
            w = rr_pick(req_valid, m_ptr);
            if ((!m_full || res_ready) && w >= 0) begin
                m_full = 1;
                m_data = req_a[w*WIDTH +: WIDTH] & req_b[w*WIDTH +: WIDTH];
                m_id   = w;
                m_ptr  = w;
                if (m_gcnt < 65535) m_gcnt++;
            end else if (res_ready) begin
                m_full = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [NREQ-1:0] exp_rdy;
        int w;
        if (started) begin
            exp_rdy = '0;
            if (rst_n && (!m_full || res_ready)) begin
                w = rr_pick(req_valid, m_ptr);
                if (w >= 0) exp_rdy[w] = 1'b1;
            end
            chk("m_req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("m_res_valid", 32'(res_valid), 32'(m_full));
            chk("m_busy", 32'(busy), 32'(m_full));
            if (m_full) begin
                chk("m_res_data", 32'(res_data), 32'(m_data));
                chk("m_res_id", 32'(res_id), 32'(m_id));
            end
`ifdef AND_SHARE_STATS_EN
            chk("m_grant_cnt", 32'(grant_cnt), 32'(m_gcnt));
            chk("m_stall_cnt", 32'(stall_cnt), 32'(m_scnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = 16'hFFFF;
            req_b[i*WIDTH +: WIDTH] = 16'(1 << i);
        end

        // Reset with everyone requesting.
        tick(); tick();
        #1;
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_res_data", 32'(res_data), 32'h0);
        chk("rst_res_id", 32'(res_id), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("first_ready", 32'(req_ready), 32'h1);

        // Rotation with all four valid: ids 0..3 repeating, data 1,2,4,8.
        for (int i = 0; i < 8; i++) begin
            tick(); #1;
            chk("rot_valid", 32'(res_valid), 32'h1);
            chk("rot_id", 32'(res_id), 32'(i % 4));
            chk("rot_data", 32'(res_data), 32'(1 << (i % 4)));
        end

        // Backpressure for three cycles while holding id 3.
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("hold_id", 32'(res_id), 32'h3);
            chk("hold_data", 32'(res_data), 32'h8);
            chk("hold_ready", 32'(req_ready), 32'h0);
            chk("hold_valid", 32'(res_valid), 32'h1);
        end
        res_ready = 1'b1;
        #1;
        chk("release_ready", 32'(req_ready), 32'h1);
        tick(); #1;
        chk("release_id", 32'(res_id), 32'h0);

        // Single requester 2.
        req_valid = 4'b0100;
        req_a[2*WIDTH +: WIDTH] = 16'h00FF;
        req_b[2*WIDTH +: WIDTH] = 16'h0F0F;
        #1;
        chk("single_ready", 32'(req_ready), 32'h4);
        tick(); #1;
        chk("single_data", 32'(res_data), 32'h000F);
        chk("single_id", 32'(res_id), 32'h2);
        chk("single_ready2", 32'(req_ready), 32'h4);
        tick(); #1;
        chk("single_id2", 32'(res_id), 32'h2);

        // Reset while full with id 1; pointer must return to NREQ-1.
        req_valid = 4'b0010;
        tick(); #1;
        chk("pre_rst_id", 32'(res_id), 32'h1);
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'h0);
        tick(); #1;
        chk("midrst_valid", 32'(res_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'h1);
        tick(); #1;
        chk("post_rst_id", 32'(res_id), 32'h0);
        chk("post_rst_data", 32'(res_data), 32'h0001);

        // Mixed pattern table, checked by the model.
        for (int i = 0; i < 48; i++) begin
            req_valid = 4'((i * 7 + 3) % 16);
            res_ready = (i % 3) != 0;
            for (int k = 0; k < NREQ; k++) begin
                req_a[k*WIDTH +: WIDTH] = 16'(i * 4321 + k * 777);
                req_b[k*WIDTH +: WIDTH] = 16'(i * 1234 + k * 5003 + 16'h5A5A);
            end
            tick();
        end

`ifdef AND_SHARE_STATS_EN
        rst_n     = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0001;
        repeat (5) tick();
        res_ready = 1'b0;
        repeat (2) tick();
        req_valid = '0;
        #1;
        chk("stats_grant5", 32'(grant_cnt), 32'd5);
        chk("stats_stall2", 32'(stall_cnt), 32'd2);
        res_ready = 1'b1;
        req_valid = 4'b0001;
        repeat (65540) tick();
        chk("stats_grant_sat", 32'(grant_cnt), 32'hFFFF);
        req_valid = '0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
